// File: rtl/contador_modn.sv
// One digit of the clock/timer datapath: modulo-MOD up/down counter with clamped
// load, cascade enable chain (cin -> cout) and an optional saturating timer mode.
module contador_modn #(
  parameter int WIDTH     = 4,
  parameter int MOD       = 10,
  parameter int RESET_VAL = MOD - 1,
  parameter bit WRAP      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             cin,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             cout,
  output logic             sat
);

  localparam logic [WIDTH-1:0] TOP  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] BOT  = '0;
  localparam logic [WIDTH-1:0] INIT = WIDTH'(RESET_VAL);

  // A bad configuration would let count escape 0..MOD-1, so refuse to elaborate.
  generate
    if (MOD < 2 || RESET_VAL < 0 || RESET_VAL >= MOD ||
        (WIDTH < 31 && (2 ** WIDTH) < MOD)) begin : g_cfg_err
      $fatal(1, "contador_modn: illegal WIDTH/MOD/RESET_VAL combination");
    end
  endgenerate

  logic [WIDTH-1:0] count_p0;
  logic             sat_p0;
  logic [WIDTH-1:0] count_nxt;
  logic             sat_nxt;
  logic             step;
  logic             term;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] d);
    if (32'(d) > 32'(MOD - 1)) return TOP;
    return d;
  endfunction

  function automatic logic at_terminal(input logic [WIDTH-1:0] c, input logic dir);
    return dir ? (c == TOP) : (c == BOT);
  endfunction

  assign step = en & cin;
  assign term = at_terminal(count_p0, up);

  always_comb begin
    count_nxt = count_p0;
    sat_nxt   = sat_p0;
    if (load) begin
      count_nxt = clamp_load(data);
      sat_nxt   = 1'b0;
    end else if (step) begin
      if (!term) begin
        count_nxt = up ? count_p0 + WIDTH'(1) : count_p0 - WIDTH'(1);
        sat_nxt   = 1'b0;
      end else if (WRAP) begin
        count_nxt = up ? BOT : TOP;
      end else begin
        sat_nxt = 1'b1;
      end
    end
  end

  // Stage p0: the only registered state of the digit
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_p0 <= INIT;
      sat_p0   <= 1'b0;
    end else begin
      count_p0 <= count_nxt;
      sat_p0   <= sat_nxt;
    end
  end

  assign count = count_p0;
  assign sat   = sat_p0;
  assign tc    = term;
  assign cout  = term & step;

endmodule

// File: tb/tb_contador_modn.sv
// Bench for contador_modn: default, mod-6 and saturating digits share stimulus and
// are tracked by an integer model; a separate mod-60 cascade pair is checked as a whole.
module tb_contador_modn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       ld = 1'b0, en = 1'b0, cin = 1'b1, up = 1'b0;
  logic [3:0] data = 4'd0;

  logic [3:0] a_cnt, c_cnt;
  logic [2:0] b_cnt;
  logic       a_tc, a_cout, a_sat, b_tc, b_cout, b_sat, c_tc, c_cout, c_sat;

  logic       k_rst = 1'b0, k_ld = 1'b0, k_en = 1'b0, k_up = 1'b1;
  logic [3:0] k_data = 4'd0, lo_cnt;
  logic [2:0] k_hdata = 3'd0, hi_cnt;
  logic       lo_tc, lo_cout, lo_sat, hi_tc, hi_cout, hi_sat;

  contador_modn u_a (.clk(clk), .reset(rst_n), .load(ld), .data(data), .en(en), .cin(cin),
                     .up(up), .count(a_cnt), .tc(a_tc), .cout(a_cout), .sat(a_sat));
  contador_modn #(.WIDTH(3), .MOD(6)) u_b (.clk(clk), .reset(rst_n), .load(ld), .data(data[2:0]),
                     .en(en), .cin(cin), .up(up), .count(b_cnt), .tc(b_tc), .cout(b_cout), .sat(b_sat));
  contador_modn #(.WRAP(1'b0)) u_c (.clk(clk), .reset(rst_n), .load(ld), .data(data), .en(en),
                     .cin(cin), .up(up), .count(c_cnt), .tc(c_tc), .cout(c_cout), .sat(c_sat));
  contador_modn u_lo (.clk(clk), .reset(k_rst), .load(k_ld), .data(k_data), .en(k_en), .cin(1'b1),
                     .up(k_up), .count(lo_cnt), .tc(lo_tc), .cout(lo_cout), .sat(lo_sat));
  contador_modn #(.WIDTH(3), .MOD(6)) u_hi (.clk(clk), .reset(k_rst), .load(k_ld), .data(k_hdata),
                     .en(k_en), .cin(lo_cout), .up(k_up), .count(hi_cnt), .tc(hi_tc), .cout(hi_cout),
                     .sat(hi_sat));

  localparam int MODS [3] = '{10, 6, 10};
  localparam int RVS  [3] = '{9, 5, 9};
  localparam int WRS  [3] = '{1, 1, 0};

  int mc [3];
  int ms [3];
  int total = 0;
  int bad = 0;

  function automatic int obs_cnt(input int id);
    case (id)
      0:       return int'(a_cnt);
      1:       return int'(b_cnt);
      default: return int'(c_cnt);
    endcase
  endfunction

  // {tc, cout, sat}
  function automatic logic [2:0] obs_flags(input int id);
    case (id)
      0:       return {a_tc, a_cout, a_sat};
      1:       return {b_tc, b_cout, b_sat};
      default: return {c_tc, c_cout, c_sat};
    endcase
  endfunction

  function automatic logic model_tc(input int id);
    return up ? (mc[id] == MODS[id] - 1) : (mc[id] == 0);
  endfunction

  function automatic void model_next(input int id, output int nc, output int ns);
    int m, d, tgt;
    m  = MODS[id];
    nc = mc[id];
    ns = ms[id];
    d  = (id == 1) ? int'(data[2:0]) : int'(data);
    tgt = up ? mc[id] + 1 : mc[id] - 1;
    if (!rst_n) begin
      nc = RVS[id]; ns = 0;
    end else if (ld) begin
      nc = (d >= m) ? m - 1 : d; ns = 0;
    end else if (en && cin) begin
      if (tgt >= 0 && tgt < m) begin
        nc = tgt; ns = 0;
      end else if (WRS[id] != 0) begin
        nc = (tgt + m) % m;
      end else begin
        ns = 1;
      end
    end
  endfunction

  task automatic cycle();
    int nc [3];
    int ns [3];
    for (int i = 0; i < 3; i++) model_next(i, nc[i], ns[i]);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      mc[i] = nc[i];
      ms[i] = ns[i];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ld = 1'b1; data = 4'd2; en = 1'b1; cin = 1'b1; up = 1'b1;
    cycle();
    total++; if (a_cnt !== 4'd9 || a_sat !== 1'b0) begin bad++;
      $display("FAIL reset_a: count=%0d sat=%0d want 9/0", a_cnt, a_sat); end
    total++; if (b_cnt !== 3'd5 || b_sat !== 1'b0) begin bad++;
      $display("FAIL reset_b: count=%0d sat=%0d want 5/0", b_cnt, b_sat); end
    total++; if (c_cnt !== 4'd9 || c_sat !== 1'b0) begin bad++;
      $display("FAIL reset_c: count=%0d sat=%0d want 9/0", c_cnt, c_sat); end
  endtask

  task automatic test_down_wrap();
    int exp_c;
    rst_n = 1'b1; ld = 1'b0; en = 1'b1; cin = 1'b1; up = 1'b0;
    #1;
    for (int i = 0; i <= 10; i++) begin
      exp_c = (19 - i) % 10;
      total++; if (a_cnt !== 4'(exp_c) || a_tc !== (exp_c == 0) || a_cout !== (exp_c == 0)) begin
        bad++;
        $display("FAIL down_wrap step %0d: count=%0d tc=%0d cout=%0d want %0d/%0d/%0d",
                 i, a_cnt, a_tc, a_cout, exp_c, exp_c == 0, exp_c == 0);
      end
      cycle();
    end
  endtask

  task automatic test_up_mod6();
    ld = 1'b1; data = 4'd0; en = 1'b1; cin = 1'b1; up = 1'b1;
    cycle();
    ld = 1'b0;
    #1;
    for (int i = 0; i <= 6; i++) begin
      total++; if (b_cnt !== 3'(i % 6) || b_tc !== (i % 6 == 5) || b_cout !== (i % 6 == 5)) begin
        bad++;
        $display("FAIL up_mod6 step %0d: count=%0d tc=%0d cout=%0d want %0d/%0d/%0d",
                 i, b_cnt, b_tc, b_cout, i % 6, i % 6 == 5, i % 6 == 5);
      end
      if (i == 5) begin
        en = 1'b0;
        #1;
        total++; if (b_cout !== 1'b0 || b_tc !== 1'b1) begin bad++;
          $display("FAIL hold_cout: tc=%0d cout=%0d want 1/0", b_tc, b_cout); end
        cycle();
        total++; if (b_cnt !== 3'd5) begin bad++;
          $display("FAIL hold_count: count=%0d want 5", b_cnt); end
        en = 1'b1;
        #1;
      end
      cycle();
    end
  endtask

  task automatic test_load_clamp();
    ld = 1'b1; data = 4'hC; en = 1'b1; cin = 1'b1; up = 1'b0;
    cycle();
    total++; if (a_cnt !== 4'd9 || a_sat !== 1'b0) begin bad++;
      $display("FAIL clamp_a: count=%0d want 9", a_cnt); end
    total++; if (b_cnt !== 3'd4) begin bad++;
      $display("FAIL clamp_b: count=%0d want 4", b_cnt); end
    data = 4'd3; en = 1'b0;
    cycle();
    total++; if (a_cnt !== 4'd3 || c_cnt !== 4'd3 || b_cnt !== 3'd3) begin bad++;
      $display("FAIL load_noen: a=%0d b=%0d c=%0d want 3", a_cnt, b_cnt, c_cnt); end
    ld = 1'b0;
  endtask

  task automatic test_priority();
    rst_n = 1'b0; ld = 1'b1; data = 4'd2; en = 1'b1; cin = 1'b1; up = 1'b1;
    cycle();
    total++; if (a_cnt !== 4'd9 || b_cnt !== 3'd5) begin bad++;
      $display("FAIL prio_reset: a=%0d b=%0d want 9/5", a_cnt, b_cnt); end
    rst_n = 1'b1;
    cycle();
    total++; if (a_cnt !== 4'd2 || c_cnt !== 4'd2) begin bad++;
      $display("FAIL prio_load: a=%0d c=%0d want 2", a_cnt, c_cnt); end
    ld = 1'b0;
  endtask

  task automatic test_saturate();
    int exp_c [3] = '{1, 0, 0};
    int exp_s [3] = '{0, 0, 1};
    ld = 1'b1; data = 4'd2; en = 1'b1; cin = 1'b1; up = 1'b0;
    cycle();
    total++; if (c_cnt !== 4'd2 || c_sat !== 1'b0) begin bad++;
      $display("FAIL sat_load: count=%0d sat=%0d want 2/0", c_cnt, c_sat); end
    ld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++; if (c_cnt !== 4'(exp_c[i]) || c_sat !== 1'(exp_s[i])) begin bad++;
        $display("FAIL sat_step %0d: count=%0d sat=%0d want %0d/%0d",
                 i, c_cnt, c_sat, exp_c[i], exp_s[i]); end
    end
    total++; if (c_tc !== 1'b1 || c_cout !== 1'b1) begin bad++;
      $display("FAIL sat_cout: tc=%0d cout=%0d want 1/1", c_tc, c_cout); end
    up = 1'b1;
    cycle();
    total++; if (c_cnt !== 4'd1 || c_sat !== 1'b0) begin bad++;
      $display("FAIL sat_leave: count=%0d sat=%0d want 1/0", c_cnt, c_sat); end
  endtask

  task automatic test_random();
    logic [2:0] f;
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(15) != 0);
      ld    = ($urandom_range(7) == 0);
      data  = 4'($urandom_range(15));
      en    = 1'($urandom_range(1));
      cin   = ($urandom_range(3) != 0);
      up    = 1'($urandom_range(1));
      #1;
      for (int i = 0; i < 3; i++) begin
        f = obs_flags(i);
        total++;
        if (f[2] !== model_tc(i) || f[1] !== (model_tc(i) & en & cin)) begin bad++;
          $display("FAIL rand_comb dut%0d cyc%0d: tc=%0d cout=%0d want %0d/%0d",
                   i, n, f[2], f[1], model_tc(i), model_tc(i) & en & cin); end
      end
      cycle();
      for (int i = 0; i < 3; i++) begin
        f = obs_flags(i);
        total++;
        if (obs_cnt(i) != mc[i] || f[0] !== 1'(ms[i])) begin bad++;
          $display("FAIL rand_state dut%0d cyc%0d: count=%0d sat=%0d want %0d/%0d",
                   i, n, obs_cnt(i), f[0], mc[i], ms[i]); end
      end
    end
  endtask

  task automatic test_cascade();
    int prev_hi, hi_moves;
    logic prev_cout;
    k_rst = 1'b1; k_ld = 1'b1; k_data = 4'd0; k_hdata = 3'd0; k_en = 1'b1; k_up = 1'b1;
    cycle();
    k_ld = 1'b0;
    hi_moves = 0;
    total++; if (hi_cnt !== 3'd0 || lo_cnt !== 4'd0) begin bad++;
      $display("FAIL casc_start: hi=%0d lo=%0d want 0/0", hi_cnt, lo_cnt); end
    for (int n = 1; n <= 60; n++) begin
      prev_hi = int'(hi_cnt);
      prev_cout = lo_cout;
      cycle();
      total++; if (int'(hi_cnt) * 10 + int'(lo_cnt) != n % 60) begin bad++;
        $display("FAIL casc_value clk%0d: hi=%0d lo=%0d want %0d", n, hi_cnt, lo_cnt, n % 60); end
      if (int'(hi_cnt) != prev_hi) begin
        hi_moves++;
        total++; if (prev_cout !== 1'b1) begin bad++;
          $display("FAIL casc_gate clk%0d: hi moved with low cout=%0d want 1", n, prev_cout); end
      end
    end
    total++; if (hi_moves != 6) begin bad++;
      $display("FAIL casc_moves: hi changed %0d times want 6", hi_moves); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin mc[i] = RVS[i]; ms[i] = 0; end
    test_reset();
    test_down_wrap();
    test_up_mod6();
    test_load_clamp();
    test_priority();
    test_saturate();
    test_random();
    test_cascade();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
